// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider.
// Operation codes, FSM states and stall request constants.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports: clk_i, rst_i (async high), start_i, op_i, dividend_i, divisor_i,
//   annul_i, stall_ex_i -> result_o, ready_o, stallreq_o.
// Option: DIV_EARLY_OUT_EN finishes |dividend| < |divisor| in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            annul_i,
  input  logic            stall_ex_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            stallreq_o
);

  localparam int CW = $clog2(XLEN);

  div_state_e      state_q, state_d;
  logic            sel_rem_q, sel_rem_d;
  logic            quo_neg_q, quo_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            sgn;
  logic            dvd_neg, dvs_neg;
  logic [XLEN-1:0] dvd_abs, dvs_abs;
  logic            div_zero, ovf;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign sgn      = (op_i == DIV_OP_DIV) | (op_i == DIV_OP_REM);
  assign dvd_neg  = sgn & dividend_i[XLEN-1];
  assign dvs_neg  = sgn & divisor_i[XLEN-1];
  assign dvd_abs  = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_abs  = dvs_neg ? -divisor_i : divisor_i;
  assign div_zero = (divisor_i == '0);
  assign ovf      = sgn
                  & (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                  & (&divisor_i);

  // quo_q doubles as the dividend shift register; its MSB feeds rem.
  assign shifted  = {rem_q, quo_q[XLEN-1]};
  assign diff     = shifted - {1'b0, dvs_q};

  assign quo_fix  = quo_neg_q ? -quo_q : quo_q;
  assign rem_fix  = rem_neg_q ? -rem_q : rem_q;

  assign ready_o  = (state_q == S_DONE) & ~annul_i;
  assign result_o = ready_o ? (sel_rem_q ? rem_fix : quo_fix) : '0;

  assign stallreq_o = (start_i & ~annul_i & (state_q != S_DONE))
                    ? STOP : NO_STOP;

  always_comb begin
    state_d   = state_q;
    sel_rem_d = sel_rem_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i & ~annul_i) begin
          sel_rem_d = (op_i == DIV_OP_REM) | (op_i == DIV_OP_REMU);
          dvs_d     = dvs_abs;
          cnt_d     = '0;
          // Special results are final; no sign fix-up in DONE.
          quo_neg_d = 1'b0;
          rem_neg_d = 1'b0;
          if (div_zero) begin
            quo_d   = '1;
            rem_d   = dividend_i;
            state_d = S_DONE;
          end else if (ovf) begin
            quo_d   = {1'b1, {(XLEN-1){1'b0}}};
            rem_d   = '0;
            state_d = S_DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (dvd_abs < dvs_abs) begin
            quo_d   = '0;
            rem_d   = dividend_i;
            state_d = S_DONE;
          end
`endif
          else begin
            quo_neg_d = dvd_neg ^ dvs_neg;
            rem_neg_d = dvd_neg;
            quo_d     = dvd_abs;
            rem_d     = '0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (annul_i | ~start_i) begin
          state_d = S_IDLE;
        end else begin
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shifted[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN-1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (annul_i | ~stall_ex_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      sel_rem_q <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_rem_q <= sel_rem_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
